// File: rtl/fp_mul_pkg.sv
// Shared FP32 field widths, constants and operand types for the multiplier operand stage.
package fp_mul_pkg;

    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int FP_W   = 32;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [FP_W-1:0]  QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } op_class_e;

    typedef struct packed {
        logic [SIGN_W-1:0] sign;
        logic [EXP_W-1:0]  exp;
        logic [MAN_W-1:0]  man;
        op_class_e         cls;
    } fp_op_t;

    // The class is consumed at push time, so a FIFO entry holds only fields and the resolved result.
    typedef struct packed {
        logic [SIGN_W-1:0] sign_x;
        logic [EXP_W-1:0]  exp_x;
        logic [MAN_W-1:0]  man_x;
        logic [SIGN_W-1:0] sign_y;
        logic [EXP_W-1:0]  exp_y;
        logic [MAN_W-1:0]  man_y;
        logic              special;
        logic [FP_W-1:0]   special_result;
    } fifo_entry_t;

endpackage

// File: rtl/fp32_unpack_classify.sv
// Combinational FP32 unpack: splits an operand into fields, flushes denormals to zero and classifies it.
import fp_mul_pkg::*;

module fp32_unpack_classify (
    input  logic [FP_W-1:0] fp_i,
    output fp_op_t          op_o
);

    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;

    assign e = fp_i[30:23];
    assign m = fp_i[22:0];

    always_comb begin
        op_o.sign = fp_i[31];
        op_o.exp  = e;
        op_o.man  = m;
        op_o.cls  = CLS_NORMAL;
        if (e == '0) begin
            op_o.exp = '0;
            op_o.man = '0;
            op_o.cls = CLS_ZERO;
        end else if (e == EXP_MAX) begin
            op_o.cls = (m == '0) ? CLS_INF : CLS_NAN;
        end
    end

endmodule

// File: rtl/fp_mul_operand_stage.sv
// FP32 operand FIFO feeding the approximate multiplier; unpacks, classifies and resolves special cases.
// Optional FP_MUL_OPERAND_STATS_EN adds saturating pop_count / special_count outputs.
import fp_mul_pkg::*;

module fp_mul_operand_stage #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP_W-1:0]   in_x,
    input  logic [FP_W-1:0]   in_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign_x,
    output logic              sign_y,
    output logic [EXP_W-1:0]  exp_x,
    output logic [EXP_W-1:0]  exp_y,
    output logic [MAN_W-1:0]  mantissa_x,
    output logic [MAN_W-1:0]  mantissa_y,
    output logic              special,
    output logic [FP_W-1:0]   special_result
`ifdef FP_MUL_OPERAND_STATS_EN
    ,
    output logic [31:0]       pop_count,
    output logic [31:0]       special_count
`endif
);

    localparam logic [PTR_W:0] CNT_FULL = DEPTH[PTR_W:0];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    fifo_entry_t      mem_q [DEPTH];

    fp_op_t      op_x, op_y;
    fifo_entry_t push_entry;
    fifo_entry_t head;
    logic        push, pop;
    logic        res_sign;

    fp32_unpack_classify u_unpack_x (.fp_i(in_x), .op_o(op_x));
    fp32_unpack_classify u_unpack_y (.fp_i(in_y), .op_o(op_y));

    assign res_sign = op_x.sign ^ op_y.sign;

    always_comb begin
        push_entry                = '0;
        push_entry.sign_x         = op_x.sign;
        push_entry.exp_x          = op_x.exp;
        push_entry.man_x          = op_x.man;
        push_entry.sign_y         = op_y.sign;
        push_entry.exp_y          = op_y.exp;
        push_entry.man_y          = op_y.man;
        if (op_x.cls == CLS_NAN || op_y.cls == CLS_NAN ||
            (op_x.cls == CLS_INF && op_y.cls == CLS_ZERO) ||
            (op_x.cls == CLS_ZERO && op_y.cls == CLS_INF)) begin
            push_entry.special        = 1'b1;
            push_entry.special_result = QNAN;
        end else if (op_x.cls == CLS_INF || op_y.cls == CLS_INF) begin
            push_entry.special        = 1'b1;
            push_entry.special_result = {res_sign, EXP_MAX, {MAN_W{1'b0}}};
        end else if (op_x.cls == CLS_ZERO || op_y.cls == CLS_ZERO) begin
            push_entry.special        = 1'b1;
            push_entry.special_result = {res_sign, {(FP_W-1){1'b0}}};
        end
    end

    // Full blocks a push even when a pop is pending, keeping in_ready purely registered.
    assign in_ready  = (count_q != CNT_FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign head           = out_valid ? mem_q[rd_ptr_q] : '0;
    assign sign_x         = head.sign_x;
    assign exp_x          = head.exp_x;
    assign mantissa_x     = head.man_x;
    assign sign_y         = head.sign_y;
    assign exp_y          = head.exp_y;
    assign mantissa_y     = head.man_y;
    assign special        = head.special;
    assign special_result = head.special_result;

`ifdef FP_MUL_OPERAND_STATS_EN
    logic [31:0] pop_cnt_q, spec_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_cnt_q  <= '0;
            spec_cnt_q <= '0;
        end else if (pop) begin
            if (pop_cnt_q != '1) pop_cnt_q <= pop_cnt_q + 1'b1;
            if (special && spec_cnt_q != '1) spec_cnt_q <= spec_cnt_q + 1'b1;
        end
    end

    assign pop_count     = pop_cnt_q;
    assign special_count = spec_cnt_q;
`endif

endmodule

// File: tb/tb_fp_mul_operand_stage.sv
// Self-checking bench for fp_mul_operand_stage: queue-based reference model plus directed literal checks.
module tb_fp_mul_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_x, in_y;
    logic        sign_x, sign_y, special;
    logic [7:0]  exp_x, exp_y;
    logic [22:0] mantissa_x, mantissa_y;
    logic [31:0] special_result;
`ifdef FP_MUL_OPERAND_STATS_EN
    logic [31:0] pop_count, special_count;
`endif

    always #5 clk = ~clk;

    fp_mul_operand_stage #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign_x(sign_x), .sign_y(sign_y), .exp_x(exp_x), .exp_y(exp_y),
        .mantissa_x(mantissa_x), .mantissa_y(mantissa_y),
        .special(special), .special_result(special_result)
`ifdef FP_MUL_OPERAND_STATS_EN
        , .pop_count(pop_count), .special_count(special_count)
`endif
    );

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
    } pair_t;

    pair_t       q[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] m_pops = 0;
    logic [31:0] m_specs = 0;
    logic        cur_v, cur_r;

    // Reference: denormals become signed zero, everything else passes through bit-exact.
    function automatic logic [31:0] flush(input logic [31:0] v);
        if ((v & 32'h7F80_0000) == 32'h0) return v & 32'h8000_0000;
        return v;
    endfunction

    // Returns {special, special_result} from IEEE magnitude comparisons.
    function automatic logic [32:0] resolve(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] ax, ay;
        logic        s, nx, ny, ix, iy, zx, zy;
        ax = x & 32'h7FFF_FFFF;
        ay = y & 32'h7FFF_FFFF;
        s  = x[31] ^ y[31];
        nx = ax > 32'h7F80_0000;
        ny = ay > 32'h7F80_0000;
        ix = ax == 32'h7F80_0000;
        iy = ay == 32'h7F80_0000;
        zx = ax < 32'h0080_0000;
        zy = ay < 32'h0080_0000;
        if (nx || ny || (ix && zy) || (iy && zx)) return {1'b1, 32'h7FC0_0000};
        if (ix || iy) return {1'b1, s, 31'h7F80_0000};
        if (zx || zy) return {1'b1, s, 31'h0};
        return 33'h0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_outputs();
        logic [31:0] fx, fy;
        logic [32:0] r;
        chk("in_ready", in_ready, q.size() != 4);
        chk("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            fx = flush(q[0].x);
            fy = flush(q[0].y);
            r  = resolve(q[0].x, q[0].y);
            chk("fields_x", {sign_x, exp_x, mantissa_x}, fx);
            chk("fields_y", {sign_y, exp_y, mantissa_y}, fy);
            chk("special", special, r[32]);
            chk("special_result", special_result, r[31:0]);
        end else begin
            chk("empty_zero", {sign_x, sign_y, exp_x, exp_y, mantissa_x, mantissa_y,
                               special, special_result}, 64'h0);
        end
`ifdef FP_MUL_OPERAND_STATS_EN
        chk("pop_count", pop_count, m_pops);
        chk("special_count", special_count, m_specs);
`endif
    endtask

    task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_x      = x;
        in_y      = y;
        out_ready = r;
        cur_v     = v;
        cur_r     = r;
        #1;
        check_outputs();
    endtask

    task automatic advance();
        logic  do_push, do_pop;
        logic [32:0] r;
        do_push = cur_v && (q.size() < 4);
        do_pop  = cur_r && (q.size() != 0);
        @(posedge clk);
        if (do_pop) begin
            r = resolve(q[0].x, q[0].y);
            m_pops++;
            if (r[32]) m_specs++;
            void'(q.pop_front());
        end
        if (do_push) q.push_back('{x: in_x, y: in_y});
    endtask

    task automatic cycle(input logic v, input logic [31:0] x, input logic [31:0] y, input logic r);
        drive(v, x, y, r);
        advance();
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] s;
        s = {$urandom_range(0, 1), 31'h0};
        case ($urandom_range(0, 7))
            0: return s;
            1: return s | $urandom_range(1, 32'h007F_FFFF);
            2: return s | 32'h7F80_0000;
            3: return s | 32'h7F80_0000 | $urandom_range(1, 32'h007F_FFFF);
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] sx [3] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000};
    logic [31:0] sy [3] = '{32'hFF80_0000, 32'h3F80_0000, 32'hC000_0000};
    logic [31:0] sr [3] = '{32'h7FC0_0000, 32'h8000_0000, 32'hFF80_0000};

    initial begin
        rst = 1'b1; in_valid = 0; in_x = 0; in_y = 0; out_ready = 0; cur_v = 0; cur_r = 0;
        repeat (2) @(negedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;

        // Basic push into empty FIFO, consumed on the first valid cycle.
        cycle(1'b1, 32'h3FC0_0000, 32'h4000_0000, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_sign_x", sign_x, 1'b0);
        chk("t1_exp_x", exp_x, 8'h7F);
        chk("t1_man_x", mantissa_x, 23'h40_0000);
        chk("t1_exp_y", exp_y, 8'h80);
        chk("t1_man_y", mantissa_y, 23'h0);
        chk("t1_special", special, 1'b0);
        advance();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        chk("t1_drained", out_valid, 1'b0);
        advance();

        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, sx[i], sy[i], 1'b1);
            drive(1'b0, 32'h0, 32'h0, 1'b1);
            chk("t2_special", special, 1'b1);
            chk("t2_result", special_result, sr[i]);
            advance();
        end

        cycle(1'b1, 32'h8000_0001, 32'h3F80_0000, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        chk("t3_denorm", {sign_x, exp_x, mantissa_x, special, special_result},
            {1'b1, 8'h0, 23'h0, 1'b1, 32'h8000_0000});
        advance();

        // Fill to full with distinct pairs, then drain in order.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h3F80_0000 | i, 32'h4000_0000 | (i + 16), 1'b0);
            chk("t4_ready_fill", in_ready, i < 4);
            advance();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1);
            chk("t4_ready_drain", in_ready, i > 0);
            chk("t4_order", mantissa_x, i);
            advance();
        end

        cycle(1'b1, 32'h4040_0000, 32'h4080_0000, 1'b0);
        cycle(1'b1, 32'hC040_0000, 32'h3F00_0000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, rand_op(), rand_op(), 1'b1);
            chk("t5_count", q.size(), 2);
        end
        repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1);

        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, rand_op(), rand_op(), $urandom_range(0, 2) != 0);
        repeat (5) cycle(1'b0, 32'h0, 32'h0, 1'b1);

        // Asynchronous reset with three entries buffered.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h3F80_0000, 32'h7F80_0000, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        cur_v    = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_valid", out_valid, 1'b0);
        chk("t6_ready", in_ready, 1'b1);
        chk("t6_fields", {special, special_result, exp_x, mantissa_x}, 64'h0);
        q.delete();
        m_pops  = 0;
        m_specs = 0;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 32'h4120_0000, 32'h3F80_0000, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        chk("t6_new_entry", {out_valid, exp_x, mantissa_x}, {1'b1, 8'h82, 23'h20_0000});
        advance();
        cycle(1'b0, 32'h0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        chk("t6_alone", out_valid, 1'b0);
        advance();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
